// File: rtl/ikaopm_timer_regs_if.sv
// CPU write bus into the timer register bank, plus the status byte returned on reads.
interface ikaopm_timer_regs_if;
  logic       i_WR_STB;
  logic       i_A0;
  logic [7:0] i_D;
  logic [7:0] o_STATUS;

  modport master (output i_WR_STB, output i_A0, output i_D, input  o_STATUS);
  modport slave  (input  i_WR_STB, input  i_A0, input  i_D, output o_STATUS);
endinterface

// File: rtl/ikaopm_timer_regs.sv
// Timer control register bank (0x01/0x10/0x11/0x12/0x14) feeding IKAOPM_timer.
// Build option: define IKAOPM_BUSY_FLAG_EN to build the write-busy counter.
module ikaopm_timer_regs #(
  parameter int BUSY_CYCLES = 64
) (
  input  logic               i_EMUCLK,
  input  logic               i_MRST_n,
  input  logic               i_phi1_NCEN_n,
  ikaopm_timer_regs_if.slave bus,
  input  logic               i_TIMERA_FLAG,
  input  logic               i_TIMERB_FLAG,
  output logic [7:0]         o_CLKA1,
  output logic [1:0]         o_CLKA2,
  output logic [7:0]         o_CLKB,
  output logic               o_TIMERA_RUN,
  output logic               o_TIMERB_RUN,
  output logic               o_TIMERA_IRQ_EN,
  output logic               o_TIMERB_IRQ_EN,
  output logic               o_TIMERA_FRST,
  output logic               o_TIMERB_FRST,
  output logic               o_CSM,
  output logic               o_TEST_D2,
  output logic               o_BUSY
);
  if (BUSY_CYCLES < 2 || BUSY_CYCLES > 255) begin : g_bad_busy_cycles
    $error("BUSY_CYCLES must be within 2..255");
  end

  logic       tick, wr_addr, wr_data, cmt;
  logic       pend_vld;
  logic [7:0] addr_lat, pend_addr, pend_d, cmt_addr, cmt_d;

  assign tick    = ~i_phi1_NCEN_n;
  assign wr_addr = bus.i_WR_STB & ~bus.i_A0;
  assign wr_data = bus.i_WR_STB &  bus.i_A0;

  // An older pending write always wins the tick; a fresh strobe only commits
  // directly when the buffer is empty.
  assign cmt      = tick & (pend_vld | wr_data);
  assign cmt_addr = pend_vld ? pend_addr : addr_lat;
  assign cmt_d    = pend_vld ? pend_d    : bus.i_D;

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      addr_lat  <= 8'h00;
      pend_vld  <= 1'b0;
      pend_addr <= 8'h00;
      pend_d    <= 8'h00;
    end else begin
      if (wr_addr) addr_lat <= bus.i_D;
      if (wr_data && (pend_vld || !tick)) begin
        pend_vld  <= 1'b1;
        pend_addr <= addr_lat;
        pend_d    <= bus.i_D;
      end else if (tick) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      o_CLKA1         <= 8'h00;
      o_CLKA2         <= 2'b00;
      o_CLKB          <= 8'h00;
      o_TIMERA_RUN    <= 1'b0;
      o_TIMERB_RUN    <= 1'b0;
      o_TIMERA_IRQ_EN <= 1'b0;
      o_TIMERB_IRQ_EN <= 1'b0;
      o_TIMERA_FRST   <= 1'b0;
      o_TIMERB_FRST   <= 1'b0;
      o_CSM           <= 1'b0;
      o_TEST_D2       <= 1'b0;
    end else if (tick) begin
      // FRST bits are never stored: they live for exactly one tick.
      o_TIMERA_FRST <= 1'b0;
      o_TIMERB_FRST <= 1'b0;
      if (cmt) begin
        case (cmt_addr)
          8'h01: o_TEST_D2 <= cmt_d[2];
          8'h10: o_CLKA1   <= cmt_d;
          8'h11: o_CLKA2   <= cmt_d[1:0];
          8'h12: o_CLKB    <= cmt_d;
          8'h14: begin
            o_TIMERA_RUN    <= cmt_d[0];
            o_TIMERB_RUN    <= cmt_d[1];
            o_TIMERA_IRQ_EN <= cmt_d[2];
            o_TIMERB_IRQ_EN <= cmt_d[3];
            o_TIMERA_FRST   <= cmt_d[4];
            o_TIMERB_FRST   <= cmt_d[5];
            o_CSM           <= cmt_d[7];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IKAOPM_BUSY_FLAG_EN
  logic [7:0] busy_cnt;

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n)             busy_cnt <= 8'h00;
    else if (tick) begin
      if (cmt)                 busy_cnt <= 8'(BUSY_CYCLES);
      else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 8'd1;
    end
  end

  assign o_BUSY = (busy_cnt != 8'h00);
`else
  assign o_BUSY = 1'b0;
`endif

  assign bus.o_STATUS = {o_BUSY, 5'b00000, i_TIMERB_FLAG, i_TIMERA_FLAG};
endmodule

// File: tb/tb_ikaopm_timer_regs.sv
// Scoreboard bench for ikaopm_timer_regs; busy expectations follow IKAOPM_BUSY_FLAG_EN.
module tb_ikaopm_timer_regs;
  localparam int BUSY_N = 64;

  logic       clk = 1'b0, rst_n = 1'b0, ncen_n = 1'b1, flag_a = 1'b0, flag_b = 1'b0;
  logic [7:0] clka1, clkb;
  logic [1:0] clka2;
  logic       run_a, run_b, irq_a, irq_b, frst_a, frst_b, csm, test_d2, busy;

  ikaopm_timer_regs_if bus ();

  ikaopm_timer_regs #(.BUSY_CYCLES(BUSY_N)) dut (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen_n), .bus(bus),
    .i_TIMERA_FLAG(flag_a), .i_TIMERB_FLAG(flag_b),
    .o_CLKA1(clka1), .o_CLKA2(clka2), .o_CLKB(clkb),
    .o_TIMERA_RUN(run_a), .o_TIMERB_RUN(run_b),
    .o_TIMERA_IRQ_EN(irq_a), .o_TIMERB_IRQ_EN(irq_b),
    .o_TIMERA_FRST(frst_a), .o_TIMERB_FRST(frst_b),
    .o_CSM(csm), .o_TEST_D2(test_d2), .o_BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] clka1;
    logic [1:0] clka2;
    logic [7:0] clkb;
    logic run_a, run_b, irq_a, irq_b, frst_a, frst_b, csm, test_d2, busy;
    logic [7:0] status;
  } snap_t;

  typedef struct { string tag; snap_t s; } sb_t;

  sb_t   expq[$];
  snap_t obsq[$];
  snap_t m;
  int    busy_m;
  int    checks = 0, errors = 0;

  function automatic snap_t observe();
    snap_t s;
    s.clka1 = clka1; s.clka2 = clka2; s.clkb = clkb;
    s.run_a = run_a; s.run_b = run_b; s.irq_a = irq_a; s.irq_b = irq_b;
    s.frst_a = frst_a; s.frst_b = frst_b; s.csm = csm; s.test_d2 = test_d2;
    s.busy = busy; s.status = bus.o_STATUS;
    return s;
  endfunction

  function automatic snap_t model_out();
    snap_t s = m;
`ifdef IKAOPM_BUSY_FLAG_EN
    s.busy = (busy_m != 0);
`else
    s.busy = 1'b0;
`endif
    s.status = {s.busy, 5'b00000, flag_b, flag_a};
    return s;
  endfunction

  // One EMUCLK cycle: tests set the register fields a commit changes before calling;
  // this handles busy count and FRST expiry, pushes the expectation, captures output.
  task automatic drv(input logic tk, stb, a0, input logic [7:0] d, input logic cmt, input string tag);
    sb_t e;
    if (tk) begin
      if (cmt) busy_m = BUSY_N;
      else begin
        if (busy_m > 0) busy_m--;
        m.frst_a = 1'b0; m.frst_b = 1'b0;
      end
    end
    e.tag = tag; e.s = model_out();
    expq.push_back(e);
    ncen_n = ~tk; bus.i_WR_STB = stb; bus.i_A0 = a0; bus.i_D = d;
    @(negedge clk);
    bus.i_WR_STB = 1'b0; ncen_n = 1'b1;
    obsq.push_back(observe());
  endtask

  task automatic test_reset();
    snap_t g, w;
    rst_n = 1'b0; #1;
    w = '0; g = observe(); checks++;
    if (g !== w) begin errors++; $display("FAIL reset_state got=%h exp=%h", g, w); end
    ncen_n = 1'b0; bus.i_WR_STB = 1'b1; bus.i_A0 = 1'b1; bus.i_D = 8'hFF;
    @(negedge clk);
    bus.i_WR_STB = 1'b0; ncen_n = 1'b1;
    g = observe(); checks++;
    if (g !== w) begin errors++; $display("FAIL reset_hold got=%h exp=%h", g, w); end
    rst_n = 1'b1; m = '0; busy_m = 0;
  endtask

  task automatic test_clka();
    sb_t e; snap_t g;
    drv(0, 1, 0, 8'h10, 0, "clka1_addr");
    drv(0, 1, 1, 8'hAB, 0, "clka1_pend");
    m.clka1 = 8'hAB;
    drv(1, 0, 0, 8'h00, 1, "clka1_commit");
    drv(0, 1, 0, 8'h11, 0, "clka2_addr");
    m.clka2 = 2'b11;
    drv(1, 1, 1, 8'hFF, 1, "clka2_same_edge");
    drv(1, 0, 0, 8'h00, 0, "clka_idle");
    while (expq.size() > 0) begin
      e = expq.pop_front(); g = obsq.pop_front(); checks++;
      if (g !== e.s) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, g, e.s); end
    end
  endtask

  task automatic test_ctrl();
    sb_t e; snap_t g;
    drv(0, 1, 0, 8'h14, 0, "ctrl_addr");
    m.run_a = 1'b1; m.irq_a = 1'b1; m.frst_a = 1'b1; m.frst_b = 1'b1;
    drv(1, 1, 1, 8'h35, 1, "ctrl_35_commit");
    drv(0, 0, 0, 8'h00, 0, "frst_hold_a");
    drv(0, 0, 0, 8'h00, 0, "frst_hold_b");
    drv(1, 0, 0, 8'h00, 0, "frst_clear");
    drv(1, 0, 0, 8'h00, 0, "ctrl_stable");
    drv(0, 1, 1, 8'h8A, 0, "csm_pend");
    m.run_a = 1'b0; m.irq_a = 1'b0; m.run_b = 1'b1; m.irq_b = 1'b1; m.csm = 1'b1;
    drv(1, 0, 0, 8'h00, 1, "csm_commit");
    drv(0, 1, 0, 8'h01, 0, "test_addr");
    m.test_d2 = 1'b1;
    drv(1, 1, 1, 8'h04, 1, "test_d2_commit");
    drv(1, 0, 0, 8'h00, 0, "ctrl_idle");
    while (expq.size() > 0) begin
      e = expq.pop_front(); g = obsq.pop_front(); checks++;
      if (g !== e.s) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, g, e.s); end
    end
  endtask

  task automatic test_last_wins();
    sb_t e; snap_t g;
    drv(0, 1, 0, 8'h12, 0, "lw_addr");
    drv(0, 1, 1, 8'h11, 0, "lw_first");
    drv(0, 1, 1, 8'h22, 0, "lw_second");
    m.clkb = 8'h22;
    drv(1, 0, 0, 8'h00, 1, "lw_commit");
    drv(1, 0, 0, 8'h00, 0, "lw_after");
    while (expq.size() > 0) begin
      e = expq.pop_front(); g = obsq.pop_front(); checks++;
      if (g !== e.s) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, g, e.s); end
    end
  endtask

  task automatic test_back_to_back();
    sb_t e; snap_t g;
    drv(0, 1, 1, 8'h33, 0, "b2b_pend_old");
    m.clkb = 8'h33;
    drv(1, 1, 1, 8'h44, 1, "b2b_old_first");
    m.clkb = 8'h44;
    drv(1, 0, 0, 8'h00, 1, "b2b_new_next");
    drv(1, 0, 0, 8'h00, 0, "b2b_idle");
    while (expq.size() > 0) begin
      e = expq.pop_front(); g = obsq.pop_front(); checks++;
      if (g !== e.s) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, g, e.s); end
    end
  endtask

  task automatic test_busy();
    sb_t e; snap_t g;
    while (busy_m > 0) drv(1, 0, 0, 8'h00, 0, "busy_drain");
    m.clkb = 8'h5A;
    drv(1, 1, 1, 8'h5A, 1, "busy_load");
    for (int i = 0; i < 29; i++) begin
      drv(0, 0, 0, 8'h00, 0, "busy_gap");
      drv(1, 0, 0, 8'h00, 0, "busy_count1");
    end
    m.clkb = 8'hA5;
    drv(1, 1, 1, 8'hA5, 1, "busy_reload");
    for (int i = 0; i < 66; i++) drv(1, 0, 0, 8'h00, 0, "busy_count2");
    while (expq.size() > 0) begin
      e = expq.pop_front(); g = obsq.pop_front(); checks++;
      if (g !== e.s) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, g, e.s); end
    end
  endtask

  task automatic test_unmapped();
    sb_t e; snap_t g;
    drv(0, 1, 0, 8'h20, 0, "unm_addr");
    drv(1, 1, 1, 8'h55, 1, "unm_commit");
    flag_b = 1'b1;
    drv(0, 0, 0, 8'h00, 0, "status_flag_b");
    drv(1, 0, 0, 8'h00, 0, "unm_tick");
    flag_b = 1'b0;
    drv(1, 0, 0, 8'h00, 0, "unm_tick2");
    while (expq.size() > 0) begin
      e = expq.pop_front(); g = obsq.pop_front(); checks++;
      if (g !== e.s) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, g, e.s); end
    end
  endtask

  task automatic test_reset_mid();
    sb_t e; snap_t g, w;
    drv(0, 1, 0, 8'h10, 0, "rm_addr");
    drv(0, 1, 1, 8'h77, 0, "rm_pend");
    #2;
    rst_n = 1'b0; flag_a = 1'b1;
    #1;
    w = '0; w.status = 8'h01; g = observe(); checks++;
    if (g !== w) begin errors++; $display("FAIL reset_async got=%h exp=%h", g, w); end
    m = '0; busy_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drv(1, 0, 0, 8'h00, 0, "rm_no_commit");
    drv(1, 0, 0, 8'h00, 0, "rm_no_commit2");
    drv(1, 1, 1, 8'hFF, 1, "rm_addr_latch_zero");
    drv(1, 0, 0, 8'h00, 0, "rm_after");
    while (expq.size() > 0) begin
      e = expq.pop_front(); g = obsq.pop_front(); checks++;
      if (g !== e.s) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, g, e.s); end
    end
  endtask

  initial begin
    bus.i_WR_STB = 1'b0; bus.i_A0 = 1'b0; bus.i_D = 8'h00;
    m = '0; busy_m = 0;
    test_reset();
    test_clka();
    test_ctrl();
    test_last_wins();
    test_back_to_back();
    test_busy();
    test_unmapped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
